// File: rtl/cp0_irq_timer.sv
// CP0 with BadVAddr/Count/Compare/Status/Cause/EPC, maskable hw/sw/timer interrupts and EXL-guarded exception entry/ERET.
// State updates one cycle after the strobe; rdata and irq_req are combinational from registered state; no backpressure.
module cp0_irq_timer #(
  parameter int          N_IRQ     = 5,
  parameter int          TIMER_DIV = 2,
  parameter logic [31:0] CMP_RST   = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mfc0,
  input  logic             mtc0,
  input  logic [4:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [31:0]      exc_pc,
  input  logic             exc_bd,
  input  logic [31:0]      exc_badva,
  input  logic             exc_badva_we,
  input  logic             eret,
  input  logic [N_IRQ-1:0] hw_irq,
  output logic             irq_req,
  output logic [31:0]      status,
  output logic [31:0]      cause,
  output logic [31:0]      epc_out
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  typedef enum logic {NORMAL = 1'b0, EXC = 1'b1} exl_state_t;

  exl_state_t        state_q, state_d;
  logic              exl, take_exc;
  logic [31:0]       badva_q, count_q, compare_q, epc_q;
  logic [PW-1:0]     presc_q;
  logic              ie_q, bd_q, ti_q;
  logic [7:0]        im_q;
  logic [1:0]        sw_ip_q;
  logic [4:0]        exc_code_q;
  logic [N_IRQ-1:0]  hw_q;
  logic [4:0]        hw_ext;
  logic [7:0]        ip;
  logic              tick, cnt_hit;
  logic [31:0]       count_inc;
  logic              wr_badva, wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_guard;

  assign wr_badva   = mtc0 && (addr == 5'd8);
  assign wr_count   = mtc0 && (addr == 5'd9);
  assign wr_compare = mtc0 && (addr == 5'd11);
  assign wr_status  = mtc0 && (addr == 5'd12);
  assign wr_cause   = mtc0 && (addr == 5'd13);
  assign wr_epc     = mtc0 && (addr == 5'd14);
  // Exception entry and ERET own EXL, EPC and Cause in the cycle they fire.
  assign wr_guard   = !exc_valid && !eret;

  always_ff @(posedge clk) begin
    if (rst) state_q <= NORMAL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (exc_valid)                  state_d = EXC;
    else if (eret)                  state_d = NORMAL;
    else if (wr_status)             state_d = wdata[1] ? EXC : NORMAL;
  end

  always_comb begin
    exl      = (state_q == EXC);
    take_exc = exc_valid && (state_q == NORMAL);
  end

  assign tick      = (presc_q == PW'(TIMER_DIV - 1));
  assign count_inc = count_q + 32'd1;
  assign cnt_hit   = tick && !wr_count && (count_inc == compare_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      badva_q    <= 32'h0;
      count_q    <= 32'h0;
      presc_q    <= '0;
      compare_q  <= CMP_RST;
      epc_q      <= 32'h0;
      ie_q       <= 1'b0;
      im_q       <= 8'h0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      sw_ip_q    <= 2'b0;
      exc_code_q <= 5'h0;
      hw_q       <= '0;
    end else begin
      hw_q <= hw_irq;

      if (wr_count) begin
        count_q <= wdata;
        presc_q <= '0;
      end else if (tick) begin
        count_q <= count_inc;
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PW'(1);
      end

      if (wr_compare) compare_q <= wdata;
      if (wr_compare)   ti_q <= 1'b0;
      else if (cnt_hit) ti_q <= 1'b1;

      if (wr_status) begin
        ie_q <= wdata[0];
        im_q <= wdata[15:8];
      end

      if (exc_valid && exc_badva_we) badva_q <= exc_badva;
      else if (wr_badva)             badva_q <= wdata;

      if (exc_valid) exc_code_q <= exc_code;
      if (take_exc) begin
        epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_q  <= exc_bd;
      end else if (wr_guard && wr_epc) begin
        epc_q <= wdata;
      end

      if (wr_guard && wr_cause) sw_ip_q <= wdata[9:8];
    end
  end

  always_comb begin
    hw_ext = 5'b0;
    for (int k = 0; k < N_IRQ; k++) hw_ext[k] = hw_q[k];
  end

  assign ip      = {ti_q, hw_ext, sw_ip_q};
  assign status  = {16'h0, im_q, 6'b0, exl, ie_q};
  assign cause   = {bd_q, ti_q, 14'h0, ip, 1'b0, exc_code_q, 2'b0};
  assign epc_out = epc_q;
  assign irq_req = ie_q && !exl && |(ip & im_q);

  always_comb begin
    rdata = 32'h0;
    if (mfc0) begin
      case (addr)
        5'd8:    rdata = badva_q;
        5'd9:    rdata = count_q;
        5'd11:   rdata = compare_q;
        5'd12:   rdata = status;
        5'd13:   rdata = cause;
        5'd14:   rdata = epc_q;
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Directed bench for cp0_irq_timer: reset map, timer compare, hw interrupt masking, exception entry/ERET, wrap and reset.
module tb_cp0_irq_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mfc0, mtc0;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badva;
  logic        exc_badva_we;
  logic        eret;
  logic [4:0]  hw_irq;
  logic        irq_req;
  logic [31:0] status, cause, epc_out;

  int tests = 0;
  int fails = 0;

  cp0_irq_timer #(.N_IRQ(5), .TIMER_DIV(2), .CMP_RST(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .addr(addr), .wdata(wdata), .rdata(rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badva(exc_badva), .exc_badva_we(exc_badva_we), .eret(eret), .hw_irq(hw_irq),
    .irq_req(irq_req), .status(status), .cause(cause), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there too.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0 = 1'b1; addr = a; wdata = d;
    cyc(1);
    mtc0 = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    mfc0 = 1'b1; addr = a;
    #1;
    chk(tag, rdata, exp);
    mfc0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mfc0 = 0; mtc0 = 0; addr = 0; wdata = 0;
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_badva = 0; exc_badva_we = 0;
    eret = 0; hw_irq = 0;
    @(negedge clk);
    cyc(2);
    rst = 1'b0;

    // Reset values
    chk("rst_irq", {31'b0, irq_req}, 32'h0);
    rd("rst_badva", 5'd8, 32'h0);
    rd("rst_count", 5'd9, 32'h0);
    rd("rst_compare", 5'd11, 32'hFFFF_FFFF);
    rd("rst_status", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("unmapped3", 5'd3, 32'h0);
    addr = 5'd11; #1;
    chk("mfc0_off", rdata, 32'h0);

    // Timer: Count reaches Compare=5 after 10 edges from a Count write
    wr(5'd11, 32'd5);
    wr(5'd12, 32'h0000_8001);
    rd("status_8001", 5'd12, 32'h0000_8001);
    wr(5'd9, 32'd0);
    cyc(9);
    rd("count_4", 5'd9, 32'd4);
    chk("ti_early", {31'b0, cause[30]}, 32'h0);
    chk("irq_early", {31'b0, irq_req}, 32'h0);
    cyc(1);
    rd("count_5", 5'd9, 32'd5);
    chk("ti_set", {31'b0, cause[30]}, 32'h1);
    chk("ip7_set", {31'b0, cause[15]}, 32'h1);
    chk("irq_timer", {31'b0, irq_req}, 32'h1);
    wr(5'd11, 32'h0000_0100);
    chk("ti_clr", {31'b0, cause[30]}, 32'h0);
    chk("irq_timer_clr", {31'b0, irq_req}, 32'h0);

    // Hardware interrupt line 0 -> IP[2], one cycle of latency
    wr(5'd12, 32'h0000_0401);
    hw_irq = 5'b00001;
    #1;
    chk("hw_lat0", {31'b0, irq_req}, 32'h0);
    cyc(1);
    chk("hw_irq_on", {31'b0, irq_req}, 32'h1);
    chk("hw_ip2", {31'b0, cause[10]}, 32'h1);
    wr(5'd12, 32'h0000_0001);
    chk("hw_masked", {31'b0, irq_req}, 32'h0);
    wr(5'd12, 32'h0000_0401);
    chk("hw_unmasked", {31'b0, irq_req}, 32'h1);

    // Exception entry from a delay slot
    exc_valid = 1; exc_pc = 32'h100; exc_bd = 1; exc_code = 5'd8;
    exc_badva_we = 1; exc_badva = 32'hDEAD_BEEF;
    cyc(1);
    exc_valid = 0; exc_badva_we = 0;
    chk("exc1_epc", epc_out, 32'h0000_00FC);
    chk("exc1_bd", {31'b0, cause[31]}, 32'h1);
    chk("exc1_code", {27'b0, cause[6:2]}, 32'd8);
    chk("exc1_exl", {31'b0, status[1]}, 32'h1);
    chk("exc1_irq_masked", {31'b0, irq_req}, 32'h0);
    rd("exc1_badva", 5'd8, 32'hDEAD_BEEF);

    // Nested exception: only ExcCode changes
    exc_valid = 1; exc_pc = 32'h200; exc_bd = 0; exc_code = 5'd4;
    cyc(1);
    exc_valid = 0;
    chk("exc2_epc", epc_out, 32'h0000_00FC);
    chk("exc2_bd", {31'b0, cause[31]}, 32'h1);
    chk("exc2_code", {27'b0, cause[6:2]}, 32'd4);
    chk("exc2_exl", {31'b0, status[1]}, 32'h1);
    rd("exc2_badva", 5'd8, 32'hDEAD_BEEF);

    eret = 1;
    cyc(1);
    eret = 0;
    chk("eret1_exl", {31'b0, status[1]}, 32'h0);
    chk("eret1_irq", {31'b0, irq_req}, 32'h1);

    // exc_valid + eret + mtc0 Status=0 in one cycle
    exc_valid = 1; exc_pc = 32'h300; exc_bd = 0; exc_code = 5'd12; eret = 1;
    mtc0 = 1; addr = 5'd12; wdata = 32'h0;
    cyc(1);
    exc_valid = 0; eret = 0; mtc0 = 0;
    chk("same_status", status, 32'h0000_0002);
    chk("same_epc", epc_out, 32'h0000_0300);
    chk("same_bd", {31'b0, cause[31]}, 32'h0);
    eret = 1;
    cyc(1);
    eret = 0;
    chk("eret2_status", status, 32'h0);

    // Count wrap onto Compare=0
    hw_irq = 5'b0;
    wr(5'd11, 32'h0);
    wr(5'd9, 32'hFFFF_FFFF);
    cyc(1);
    rd("wrap_pre", 5'd9, 32'hFFFF_FFFF);
    chk("wrap_ti_pre", {31'b0, cause[30]}, 32'h0);
    cyc(1);
    rd("wrap_count", 5'd9, 32'h0);
    chk("wrap_ti", {31'b0, cause[30]}, 32'h1);

    // Reset mid-run
    wr(5'd12, 32'h0000_8003);
    wr(5'd14, 32'h1234_5678);
    cyc(3);
    rst = 1;
    cyc(1);
    rst = 0;
    rd("mrst_count", 5'd9, 32'h0);
    chk("mrst_cause", cause, 32'h0);
    chk("mrst_status", status, 32'h0);
    chk("mrst_epc", epc_out, 32'h0);
    rd("mrst_compare", 5'd11, 32'hFFFF_FFFF);
    chk("mrst_irq", {31'b0, irq_req}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
